// File: rtl/pwm_ramp_ctrl.sv
// Ramp sequencer for the PWM block: steps duty toward a target one dwell at a time,
// applying every change only on a PWM period boundary and never driving an illegal setting.
module pwm_ramp_ctrl #(
    parameter int W        = 8,
    parameter int MIN_DUTY = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [W-1:0] cmd_period,
    input  logic [W-1:0] cmd_target,
    input  logic [W-1:0] cmd_step,
    input  logic [W-1:0] cmd_dwell,
    input  logic         stop,
    input  logic [W-1:0] pwm_cnt,
    output logic         pwm_en,
    output logic [W-1:0] pwm_period,
    output logic [W-1:0] pwm_duty,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_RAMP     = 2'd1;
    localparam logic [1:0] S_SETTLED  = 2'd2;
    localparam logic [1:0] S_STOPPING = 2'd3;

    localparam logic [W-1:0] DUTY_MIN = W'(MIN_DUTY);

    logic [1:0]   state_q, state_d;
    logic         pwm_en_q, pwm_en_d;
    logic [W-1:0] pwm_period_q, pwm_period_d;
    logic [W-1:0] pwm_duty_q, pwm_duty_d;
    logic         done_q, done_d;
    logic         err_q, err_d;
    logic [W-1:0] tgt_q, tgt_d;
    logic [W-1:0] step_q, step_d;
    logic [W-1:0] dwell_q, dwell_d;
    logic [W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic         sh_vld_q, sh_vld_d;
    logic [W-1:0] sh_period_q, sh_period_d;
    logic [W-1:0] sh_tgt_q, sh_tgt_d;
    logic [W-1:0] sh_step_q, sh_step_d;
    logic [W-1:0] sh_dwell_q, sh_dwell_d;

    logic         boundary, accept, legal;
    logic [W-1:0] tgt_lo, tgt_eff, step_eff, dwell_eff;
    logic [W:0]   duty_up;
    logic [W-1:0] ramp_duty, sh_duty;

    always_comb begin
        unique case (state_q)
            S_IDLE:     cmd_ready = 1'b1;
            S_STOPPING: cmd_ready = 1'b0;
            default:    cmd_ready = !sh_vld_q;
        endcase
    end

    assign boundary = pwm_en_q && (pwm_cnt == pwm_period_q);
    assign accept   = cmd_valid && cmd_ready;
    assign legal    = cmd_period >= W'(2);

    // Target is clamped into the legal duty window of the command's own period.
    assign tgt_lo    = (cmd_target < DUTY_MIN) ? DUTY_MIN : cmd_target;
    assign tgt_eff   = (tgt_lo > cmd_period - W'(1)) ? cmd_period - W'(1) : tgt_lo;
    assign step_eff  = (cmd_step == '0) ? W'(1) : cmd_step;
    assign dwell_eff = (cmd_dwell == '0) ? W'(1) : cmd_dwell;

    // Saturating step toward the target: the extra bit keeps duty+step from wrapping.
    assign duty_up = {1'b0, pwm_duty_q} + {1'b0, step_q};
    always_comb begin
        if (pwm_duty_q < tgt_q)
            ramp_duty = (duty_up >= {1'b0, tgt_q}) ? tgt_q : duty_up[W-1:0];
        else
            ramp_duty = (pwm_duty_q - tgt_q <= step_q) ? tgt_q : pwm_duty_q - step_q;
    end

    assign sh_duty = (pwm_duty_q > sh_period_q - W'(1)) ? sh_period_q - W'(1) : pwm_duty_q;

    always_comb begin
        state_d      = state_q;
        pwm_en_d     = pwm_en_q;
        pwm_period_d = pwm_period_q;
        pwm_duty_d   = pwm_duty_q;
        done_d       = 1'b0;
        err_d        = accept && !legal;
        tgt_d        = tgt_q;
        step_d       = step_q;
        dwell_d      = dwell_q;
        dwell_cnt_d  = dwell_cnt_q;
        sh_vld_d     = sh_vld_q;
        sh_period_d  = sh_period_q;
        sh_tgt_d     = sh_tgt_q;
        sh_step_d    = sh_step_q;
        sh_dwell_d   = sh_dwell_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept && legal) begin
                    pwm_en_d     = 1'b1;
                    pwm_period_d = cmd_period;
                    pwm_duty_d   = DUTY_MIN;
                    tgt_d        = tgt_eff;
                    step_d       = step_eff;
                    dwell_d      = dwell_eff;
                    dwell_cnt_d  = dwell_eff;
                    done_d       = (tgt_eff == DUTY_MIN);
                    state_d      = (tgt_eff == DUTY_MIN) ? S_SETTLED : S_RAMP;
                end
            end
            S_STOPPING: begin
                if (boundary) begin
                    pwm_en_d = 1'b0;
                    sh_vld_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                if (accept && legal) begin
                    sh_vld_d    = 1'b1;
                    sh_period_d = cmd_period;
                    sh_tgt_d    = tgt_eff;
                    sh_step_d   = step_eff;
                    sh_dwell_d  = dwell_eff;
                end
                if (stop) begin
                    state_d = S_STOPPING;
                end else if (boundary && sh_vld_q) begin
                    sh_vld_d     = 1'b0;
                    pwm_period_d = sh_period_q;
                    pwm_duty_d   = sh_duty;
                    tgt_d        = sh_tgt_q;
                    step_d       = sh_step_q;
                    dwell_d      = sh_dwell_q;
                    dwell_cnt_d  = sh_dwell_q;
                    done_d       = (sh_duty == sh_tgt_q);
                    state_d      = (sh_duty == sh_tgt_q) ? S_SETTLED : S_RAMP;
                end else if (boundary && state_q == S_RAMP) begin
                    if (dwell_cnt_q <= W'(1)) begin
                        pwm_duty_d  = ramp_duty;
                        dwell_cnt_d = dwell_q;
                        if (ramp_duty == tgt_q) begin
                            done_d  = 1'b1;
                            state_d = S_SETTLED;
                        end
                    end else begin
                        dwell_cnt_d = dwell_cnt_q - W'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            pwm_en_q     <= 1'b0;
            pwm_period_q <= W'(2);
            pwm_duty_q   <= DUTY_MIN;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            tgt_q        <= DUTY_MIN;
            step_q       <= W'(1);
            dwell_q      <= W'(1);
            dwell_cnt_q  <= '0;
            sh_vld_q     <= 1'b0;
            sh_period_q  <= W'(2);
            sh_tgt_q     <= DUTY_MIN;
            sh_step_q    <= W'(1);
            sh_dwell_q   <= W'(1);
        end else begin
            state_q      <= state_d;
            pwm_en_q     <= pwm_en_d;
            pwm_period_q <= pwm_period_d;
            pwm_duty_q   <= pwm_duty_d;
            done_q       <= done_d;
            err_q        <= err_d;
            tgt_q        <= tgt_d;
            step_q       <= step_d;
            dwell_q      <= dwell_d;
            dwell_cnt_q  <= dwell_cnt_d;
            sh_vld_q     <= sh_vld_d;
            sh_period_q  <= sh_period_d;
            sh_tgt_q     <= sh_tgt_d;
            sh_step_q    <= sh_step_d;
            sh_dwell_q   <= sh_dwell_d;
        end
    end

    assign pwm_en     = pwm_en_q;
    assign pwm_period = pwm_period_q;
    assign pwm_duty   = pwm_duty_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: doc/pwm_ramp_ctrl.md
Name: pwm_ramp_ctrl

Overview:
Sequencer that drives the PWM block's period, duty-cycle and enable inputs. It accepts ramp commands through a valid/ready handshake and steps the duty cycle toward a target, with a programmable dwell measured in PWM periods. It applies every change only at a PWM period boundary. It also enforces the PWM legality rules (period > 1, 0 < duty < period) so the PWM never sees an illegal configuration.

Parameters:
W, 8, width of period/duty/step/counter fields
MIN_DUTY, 1, lowest duty ever driven while enabled

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_period  in  W  PWM period for this command
cmd_target  in  W  target duty
cmd_step  in  W  duty increment/decrement per dwell (0 treated as 1)
cmd_dwell  in  W  PWM periods per step (0 treated as 1)
stop  in  1  pulse; disable PWM at next boundary
pwm_cnt  in  W  PWM counter feedback (io_contador)
pwm_en  out  1  to PWM io_en
pwm_period  out  W  to PWM io_periodCounter
pwm_duty  out  W  to PWM io_dutyCicle
busy  out  1  state != IDLE
done  out  1  1-cycle pulse when duty first equals target
err  out  1  1-cycle pulse on rejected command

Behaviour:
- Reset (reset==0 at posedge): state=IDLE, pwm_en=0, pwm_period=2, pwm_duty=MIN_DUTY, done=0, err=0, shadow register empty, dwell counter=0. Reset mid-ramp aborts immediately; no boundary wait.
- boundary = pwm_en && (pwm_cnt == pwm_period); evaluated combinationally, acted on at the same posedge.
- Command legality: cmd_period >= 2. An illegal command is still accepted (handshake completes), pulses err the next cycle, and is otherwise discarded.
- Target clamp: eff_target = min(max(cmd_target, MIN_DUTY), cmd_period-1).
- States:
  - IDLE: cmd_ready=1, pwm_en=0. On a legal accept: pwm_period<=cmd_period, pwm_duty<=MIN_DUTY, latch eff_target/step/dwell, dwell counter<=dwell, pwm_en<=1, go RAMP. If eff_target==MIN_DUTY, go SETTLED and pulse done the next cycle.
  - RAMP: each boundary decrements the dwell counter. When it would reach 0: duty moves toward the target by step, saturating at the target (no overshoot, no wrap), and the counter reloads to dwell. When the new duty == target: go SETTLED and pulse done.
  - SETTLED: duty held; pwm_en=1.
  - STOPPING: entered from RAMP/SETTLED on stop. Duty/period frozen. At the next boundary: pwm_en<=0, go IDLE. stop in IDLE is ignored.
- Shadow command: in RAMP/SETTLED, cmd_ready = shadow empty. An accepted legal command fills the shadow. At the next boundary the shadow loads: period, target, step and dwell are latched; pwm_duty<=min(current duty, new period-1); dwell counter reloads; go RAMP (or SETTLED+done if already at the target); shadow is emptied. cmd_ready=0 in STOPPING.
- Simultaneous events:
  - stop and a shadow load on the same boundary: stop wins; the shadow is discarded.
  - stop and an accept in the same cycle: the accept completes; the shadow is discarded at the stop boundary.
- Arithmetic is W-bit unsigned with saturating step logic computed at W+1 bits. The outputs always satisfy MIN_DUTY <= pwm_duty < pwm_period while pwm_en=1.
- All outputs are registered; pwm_* change only in the cycle after a boundary or an IDLE accept.

Test Plan:
- Reset held low 3 cycles, then high -> pwm_en=0, busy=0, cmd_ready=1, pwm_period=2, pwm_duty=1.
- IDLE accept period=10, target=7, step=2, dwell=1 -> duty 1→3→5→7 on successive boundaries (pwm_cnt==10); done pulses once when duty=7; state SETTLED.
- Target 50 with period 10 -> clamped to 9. Period 1 -> err pulse, state stays IDLE, pwm_en=0.
- In SETTLED (period 10, duty 7), accept period=6, target=2, step=1, dwell=2 -> at the next boundary period=6, duty=5; duty then goes 4, 3, 2, stepping every 2nd boundary; done pulses at 2.
- stop mid-RAMP plus a pending shadow -> outputs frozen until pwm_cnt==pwm_period; then pwm_en=0, IDLE, shadow dropped, no done.
- reset driven low during RAMP (not at a boundary) -> next cycle pwm_en=0, state IDLE, no done/err pulse.
